// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multicycle RISC-V core: sequences fetch/decode/execute/memory/writeback
// and drives the datapath strobes and selects, with a memory-ready stall and a sticky illegal-op trap.
module multicycle_main_fsm #(
   parameter bit MEM_WAIT_EN = 1'b1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [6:0] op,
   input  logic       mem_ready,
   output logic       Branch,
   output logic       PCUpdate,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       AdrSrc,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [3:0] state_o,
   output logic       illegal_op
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECI    = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10,
      S_TRAP     = 4'd11
   } state_t;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_RTYP = 7'b0110011;
   localparam logic [6:0] OP_IALU = 7'b0010011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;

   state_t r_state;
   state_t w_next;
   logic   w_rdy;

   logic w_branch;
   logic w_pcupdate;
   logic w_regwrite;
   logic w_memwrite;
   logic w_irwrite;
   logic w_illegal;

   assign w_rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = S_FETCH;
      case (r_state)
         S_FETCH:    w_next = w_rdy ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: w_next = S_MEMADR;
               OP_RTYP:      w_next = S_EXECR;
               OP_IALU:      w_next = S_EXECI;
               OP_JAL:       w_next = S_JAL;
               OP_BEQ:       w_next = S_BEQ;
               default:      w_next = S_TRAP;
            endcase
         end
         S_MEMADR: begin
            if (op == OP_LW)      w_next = S_MEMREAD;
            else if (op == OP_SW) w_next = S_MEMWRITE;
            else                  w_next = S_TRAP;
         end
         S_MEMREAD:  w_next = w_rdy ? S_MEMWB : S_MEMREAD;
         S_MEMWB:    w_next = S_FETCH;
         S_MEMWRITE: w_next = w_rdy ? S_FETCH : S_MEMWRITE;
         S_EXECR:    w_next = S_ALUWB;
         S_EXECI:    w_next = S_ALUWB;
         S_JAL:      w_next = S_ALUWB;
         S_ALUWB:    w_next = S_FETCH;
         S_BEQ:      w_next = S_FETCH;
         S_TRAP:     w_next = S_TRAP;
         default:    w_next = S_FETCH;
      endcase
   end

   always_comb begin
      w_branch   = 1'b0;
      w_pcupdate = 1'b0;
      w_regwrite = 1'b0;
      w_memwrite = 1'b0;
      w_irwrite  = 1'b0;
      w_illegal  = 1'b0;
      AdrSrc     = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ALUOp      = 2'b00;
      case (r_state)
         S_FETCH: begin
            ALUSrcB    = 2'b10;
            ResultSrc  = 2'b10;
            w_irwrite  = w_rdy;
            w_pcupdate = w_rdy;
         end
         S_DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
         end
         S_MEMREAD: begin
            AdrSrc = 1'b1;
         end
         S_MEMWB: begin
            ResultSrc  = 2'b01;
            w_regwrite = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc     = 1'b1;
            w_memwrite = w_rdy;
         end
         S_EXECR: begin
            ALUSrcA = 2'b10;
            ALUOp   = 2'b10;
         end
         S_EXECI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            ALUOp   = 2'b10;
         end
         S_ALUWB: begin
            w_regwrite = 1'b1;
         end
         S_JAL: begin
            ALUSrcA    = 2'b01;
            ALUSrcB    = 2'b10;
            w_pcupdate = 1'b1;
         end
         S_BEQ: begin
            ALUSrcA  = 2'b10;
            ALUOp    = 2'b01;
            w_branch = 1'b1;
         end
         S_TRAP: begin
            w_illegal = 1'b1;
         end
         default: begin
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
         end
      endcase
   end

   // Strobes are gated by reset_n directly so an asynchronous reset mid-cycle
   // suppresses any write without waiting for the state register to settle.
   assign Branch     = w_branch   & reset_n;
   assign PCUpdate   = w_pcupdate & reset_n;
   assign RegWrite   = w_regwrite & reset_n;
   assign MemWrite   = w_memwrite & reset_n;
   assign IRWrite    = w_irwrite  & reset_n;
   assign illegal_op = w_illegal  & reset_n;
   assign state_o    = r_state;

endmodule
